// File: rtl/ins_fetch_pkg.sv
// Shared fetch-stage types and constants.
package ins_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// Fetch-stage bus: imem request/response channel, decode stall/redirect inputs and the IF/ID entry.
interface ins_fetch_if;
  import ins_fetch_pkg::*;

  logic            imem_req_valid_out;
  logic [XLEN-1:0] imem_req_addr_out;
  logic            imem_req_ready_in;
  logic            imem_resp_valid_in;
  logic [XLEN-1:0] imem_resp_data_in;
  logic            pipeline_stall_in;
  logic            redirect_valid_in;
  logic [XLEN-1:0] redirect_pc_in;
  logic            if_valid_out;
  logic [XLEN-1:0] if_instruction_out;
  logic [XLEN-1:0] if_pc_out;
  logic [XLEN-1:0] if_pc_plus_4_out;

  modport master (
    output imem_req_valid_out, imem_req_addr_out,
    input  imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in,
    input  pipeline_stall_in, redirect_valid_in, redirect_pc_in,
    output if_valid_out, if_instruction_out, if_pc_out, if_pc_plus_4_out
  );

  modport slave (
    input  imem_req_valid_out, imem_req_addr_out,
    output imem_req_ready_in, imem_resp_valid_in, imem_resp_data_in,
    output pipeline_stall_in, redirect_valid_in, redirect_pc_in,
    input  if_valid_out, if_instruction_out, if_pc_out, if_pc_plus_4_out
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush; head is read straight from registered storage (no bypass).
// Push on a full FIFO is accepted only alongside a pop; flush overrides push and pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & ((r_count != CW'(DEPTH)) | w_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ins_fetch.sv
// Fetch stage: PC, in-order imem requests under a FIFO_DEPTH credit, buffered IF/ID entry (NOP when empty).
// 1-cycle memory: request N -> if_valid_out N+2; stall freezes IF/ID, redirect flushes; FETCH_PERF_CNT_EN adds perf counters.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  ins_fetch_if.master     bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [XLEN-1:0] perf_fetch_count_out,
  output logic [XLEN-1:0] perf_flush_count_out
`endif
);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_drop_cnt;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_tag_count;
  logic [XLEN-1:0] w_tag_head;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_dat;
  logic [CW1-1:0]  w_credit_used;
  logic [XLEN-1:0] w_if_pc;
  logic            w_valid, w_deq, w_redirect, w_req_vld, w_req_fire;
  logic            w_resp, w_drop, w_push;

  assign w_redirect    = bus.redirect_valid_in;
  assign w_resp        = bus.imem_resp_valid_in;
  assign w_valid       = (w_count != '0);
  assign w_deq         = w_valid & ~bus.pipeline_stall_in & ~w_redirect;
  assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_count} - CW1'(w_deq);
  assign w_req_vld     = ~rst & ~w_redirect & (w_credit_used < CW1'(FIFO_DEPTH));
  assign w_req_fire    = w_req_vld & bus.imem_req_ready_in;
  assign w_drop        = w_resp & (r_drop_cnt != '0);
  assign w_push        = w_resp & ~w_drop & ~w_redirect;
  assign w_push_dat    = {bus.imem_resp_data_in, w_tag_head};

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_deq),
    .i_flush    (w_redirect),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Tags track every in-flight request, dropped or not, so this queue is never flushed.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(XLEN)) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_req_fire),
    .i_push_dat (r_pc),
    .i_pop      (w_resp),
    .i_flush    (1'b0),
    .o_head     (w_tag_head),
    .o_count    (w_tag_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= word_align(RESET_PC);
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_resp);
      if (w_redirect) begin
        r_pc       <= word_align(bus.redirect_pc_in);
        // r_outstanding already counts pending drops, so this is drop_cnt + live requests - this response.
        r_drop_cnt <= r_outstanding - CW'(w_resp);
      end else begin
        if (w_req_fire) r_pc <= r_pc + XLEN'(4);
        if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  assign w_if_pc                = w_valid ? w_head.pc : '0;
  assign bus.imem_req_valid_out = w_req_vld;
  assign bus.imem_req_addr_out  = r_pc;
  assign bus.if_valid_out       = w_valid;
  assign bus.if_instruction_out = w_valid ? w_head.instr : NOP_INSTR;
  assign bus.if_pc_out          = w_if_pc;
  assign bus.if_pc_plus_4_out   = w_if_pc + XLEN'(4);

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && (w_count == CW'(FIFO_DEPTH)) && !w_deq));
  a_no_spurious_resp : assert property (@(posedge clk) disable iff (rst)
    !(w_resp && (r_outstanding == '0)));
  a_tags_match : assert property (@(posedge clk) disable iff (rst)
    (w_tag_count == r_outstanding));

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] r_perf_fetch;
  logic [XLEN-1:0] r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_deq)      r_perf_fetch <= r_perf_fetch + XLEN'(1);
      if (w_redirect) r_perf_flush <= r_perf_flush + XLEN'(1);
    end
  end

  assign perf_fetch_count_out = r_perf_fetch;
  assign perf_flush_count_out = r_perf_flush;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: in-order memory model plus a program-order stream model of the IF/ID output.
module tb_ins_fetch;
  import ins_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ins_fetch_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  ins_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetch_count_out (perf_fetch)
    , .perf_flush_count_out (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;
  int n_deq = 0;
  int n_deq_all = 0;
  int n_flush = 0;
  int first_vld = -1;
  int unsigned mq_addr[$];
  int          mq_due[$];
  logic [31:0] exp_pc, exp_req;
  logic        flush_pend = 1'b0;
  logic        rst_pend = 1'b0;
  logic        s_valid, s_req_vld;
  logic [31:0] s_instr, s_pc, s_pc4, s_addr;
  logic        r_st, r_rd, r_rdy, r_rs;
  logic [31:0] r_rpc;
  int          d0;
  logic        found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    if (a == 32'h4) return 32'h0020_0113;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%08h exp=%08h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at posedge+1, memory answers in order, sample and model at negedge.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic rs);
    rst                   = rs;
    bus.pipeline_stall_in = st;
    bus.redirect_valid_in = rd;
    bus.redirect_pc_in    = rpc;
    bus.imem_req_ready_in = rdy;
    if (rs) begin
      mq_addr.delete();
      mq_due.delete();
    end
    if (!rs && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_resp_valid_in = 1'b1;
      bus.imem_resp_data_in  = mem_word(mq_addr[0]);
    end else begin
      bus.imem_resp_valid_in = 1'b0;
      bus.imem_resp_data_in  = $urandom;
    end
    @(negedge clk);
    s_valid   = bus.if_valid_out;
    s_instr   = bus.if_instruction_out;
    s_pc      = bus.if_pc_out;
    s_pc4     = bus.if_pc_plus_4_out;
    s_req_vld = bus.imem_req_valid_out;
    s_addr    = bus.imem_req_addr_out;
    if (rs) begin
      check_eq("req_vld_in_rst", 32'(s_req_vld), 32'd0);
      exp_pc     = RST_PC;
      exp_req    = RST_PC;
      rst_pend   = 1'b1;
      flush_pend = 1'b0;
      n_deq      = 0;
      n_flush    = 0;
      first_vld  = -1;
      cyc        = -1;
    end else begin
      if (rst_pend) begin
        check_eq("rst_vld", 32'(s_valid), 32'd0);
        check_eq("rst_instr", s_instr, NOP_INSTR);
        check_eq("rst_pc", s_pc, 32'd0);
        check_eq("rst_pc4", s_pc4, 32'd4);
      end else if (flush_pend) begin
        check_eq("flush_vld", 32'(s_valid), 32'd0);
      end
      rst_pend = 1'b0;
`ifdef FETCH_PERF_CNT_EN
      check_eq("perf_fetch", perf_fetch, 32'(n_deq));
      check_eq("perf_flush", perf_flush, 32'(n_flush));
`endif
      if (s_valid) begin
        check_eq("if_pc", s_pc, exp_pc);
        check_eq("if_instr", s_instr, mem_word(exp_pc));
        check_eq("if_pc4", s_pc4, exp_pc + 32'd4);
        if (first_vld < 0) first_vld = cyc;
      end else begin
        check_eq("nop_instr", s_instr, NOP_INSTR);
      end
      if (s_req_vld) check_eq("req_addr", s_addr, exp_req);
      flush_pend = rd;
      if (rd) begin
        check_eq("req_in_redirect", 32'(s_req_vld), 32'd0);
        exp_pc  = {rpc[31:2], 2'b00};
        exp_req = exp_pc;
        n_flush++;
      end else begin
        if (s_valid && !st) begin
          exp_pc = exp_pc + 32'd4;
          n_deq++;
          n_deq_all++;
        end
        if (s_req_vld && rdy) begin
          mq_addr.push_back(s_addr);
          mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
          exp_req = exp_req + 32'd4;
        end
      end
      if (bus.imem_resp_valid_in) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      check_eq("credit", 32'(mq_addr.size() <= DEPTH), 32'd1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n, input logic st, input logic rdy);
    for (int i = 0; i < n; i++) cycle(st, 1'b0, 32'd0, rdy, 1'b0);
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    do begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      i++;
    end while (!s_valid && i < max);
    check_eq(tag, 32'(s_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pipeline_stall_in  = 1'b0;
    bus.redirect_valid_in  = 1'b0;
    bus.redirect_pc_in     = 32'd0;
    bus.imem_req_ready_in  = 1'b1;
    bus.imem_resp_valid_in = 1'b0;
    bus.imem_resp_data_in  = 32'd0;
    repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Reset release with 1-cycle memory: back-to-back requests, first entry at cycle 2, then 1/cycle.
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t1_req0_vld", 32'(s_req_vld), 32'd1);
    check_eq("t1_req0_addr", s_addr, 32'h0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t1_req1_vld", 32'(s_req_vld), 32'd1);
    check_eq("t1_req1_addr", s_addr, 32'h4);
    run_n(20, 1'b0, 1'b1);
    check_eq("t1_first_vld_cyc", 32'(first_vld), 32'd2);
    check_eq("t1_throughput", 32'(n_deq), 32'd20);

    // Stall with a full buffer: no requests, entry held; release resumes at full rate.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      check_eq("t2_stall_req", 32'(s_req_vld), 32'd0);
      check_eq("t2_stall_vld", 32'(s_valid), 32'd1);
    end
    d0 = n_deq;
    run_n(10, 1'b0, 1'b1);
    check_eq("t2_resume_rate", 32'(n_deq - d0), 32'd10);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat_min = 3;
    lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (mq_addr.size() == 2) found = 1'b1;
    end
    check_eq("t3_two_outstanding", 32'(found), 32'd1);
    cycle(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
    wait_valid("t3_new_path_vld", 20);
    check_eq("t3_new_pc", s_pc, 32'h100);

    // Memory not ready for 5 cycles: request held, buffer drains to NOP.
    lat_min = 1;
    lat_max = 1;
    run_n(10, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check_eq("t4_req_held", 32'(s_req_vld), 32'd1);
    end
    check_eq("t4_drained_vld", 32'(s_valid), 32'd0);
    check_eq("t4_drained_nop", s_instr, NOP_INSTR);

    // Unaligned redirect coinciding with stall and a returning response.
    run_n(10, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'h102, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("t5_vld_after", 32'(s_valid), 32'd0);
    check_eq("t5_req_vld", 32'(s_req_vld), 32'd1);
    check_eq("t5_req_addr", s_addr, 32'h100);
    wait_valid("t5_vld", 10);
    check_eq("t5_pc", s_pc, 32'h100);

    // Address wrap at the top of the space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_valid("wrap_vld", 10);
    check_eq("wrap_pc", s_pc, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", s_pc4, 32'h0);
    run_n(4, 1'b0, 1'b1);

    // Randomised traffic: stalls, backpressure, redirects, occasional mid-run reset.
    for (int blk = 0; blk < 6; blk++) begin
      lat_min = 1;
      lat_max = int'($urandom_range(4, 1));
      for (int i = 0; i < 500; i++) begin
        r_rs  = ($urandom_range(999, 0) < 3);
        r_rd  = !r_rs && ($urandom_range(99, 0) < 4);
        r_st  = ($urandom_range(99, 0) < 25);
        r_rdy = ($urandom_range(99, 0) < 75);
        r_rpc = {20'h0, 12'($urandom)};
        cycle(r_st, r_rd, r_rpc, r_rdy, r_rs);
      end
    end
    check_eq("progress", 32'(n_deq_all > 500), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
